// File: rtl/apb4_mem_slave.sv
// APB4 memory-mapped slave: byte-strobed word RAM with configurable wait states,
// registered response outputs and address/range error signalling.
module apb4_mem_slave #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 12,
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                psel,
  input  logic                penable,
  input  logic                pwrite,
  input  logic [ADDR_W-1:0]   paddr,
  input  logic [DATA_W-1:0]   pwdata,
  input  logic [DATA_W/8-1:0] pstrb,
  output logic [DATA_W-1:0]   prdata,
  output logic                pready,
  output logic                pslverr
);

  localparam int NB    = DATA_W / 8;
  localparam int LSB   = (NB > 1) ? $clog2(NB) : 0;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W-1:0] LOW_MASK = ADDR_W'((1 << LSB) - 1);
  localparam logic [ADDR_W:0]   DEPTH_L  = (ADDR_W + 1)'(DEPTH);
  localparam logic [3:0]        CNT_INIT = 4'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2} state_e;

  state_e              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [ADDR_W-1:0]   addr_q;
  logic                write_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [NB-1:0]       strb_q;
  logic [DATA_W-1:0]   prdata_q, prdata_d;
  logic                pready_q, pready_d;
  logic                pslverr_q, pslverr_d;

  logic [DATA_W-1:0]   mem [0:DEPTH-1];

  logic                setup;
  logic [ADDR_W-1:0]   acc_addr;
  logic                acc_write;
  logic [DATA_W-1:0]   acc_wdata;
  logic [NB-1:0]       acc_strb;
  logic [ADDR_W-1:0]   word_idx;
  logic [IDX_W-1:0]    mem_idx;
  logic                acc_err;
  logic                enter_resp;
  logic                mem_we;
  logic [DATA_W-1:0]   wmask;

  assign setup = psel & ~penable;

  // With zero wait states RESP is entered on the setup edge itself, so the
  // access must use the live bus rather than the not-yet-latched copy.
  assign acc_addr  = (state_q == IDLE) ? paddr  : addr_q;
  assign acc_write = (state_q == IDLE) ? pwrite : write_q;
  assign acc_wdata = (state_q == IDLE) ? pwdata : wdata_q;
  assign acc_strb  = (state_q == IDLE) ? pstrb  : strb_q;

  assign word_idx = acc_addr >> LSB;
  assign mem_idx  = word_idx[IDX_W-1:0];
  assign acc_err  = (|(acc_addr & LOW_MASK)) | ({1'b0, word_idx} >= DEPTH_L);

  generate
    for (genvar gi = 0; gi < NB; gi++) begin : g_lane
      assign wmask[gi*8 +: 8] = {8{acc_strb[gi]}};
    end
  endgenerate

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (setup) begin
          if (WAIT_CYCLES == 0) begin
            state_d = RESP;
          end else begin
            state_d = WAIT;
            cnt_d   = CNT_INIT;
          end
        end
      end
      WAIT: begin
        if (!psel) begin
          state_d = IDLE;
          cnt_d   = 4'd0;
        end else if (cnt_q == 4'd0) begin
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    enter_resp = (state_d == RESP);
    pready_d   = enter_resp;
    pslverr_d  = enter_resp & acc_err;
    prdata_d   = '0;
    if (enter_resp && !acc_write && !acc_err) begin
      prdata_d = mem[mem_idx];
    end
    mem_we = enter_resp & acc_write & ~acc_err & rst_n;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= 4'd0;
      addr_q    <= '0;
      write_q   <= 1'b0;
      wdata_q   <= '0;
      strb_q    <= '0;
      prdata_q  <= '0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      prdata_q  <= prdata_d;
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
      if (state_q == IDLE && setup) begin
        addr_q  <= paddr;
        write_q <= pwrite;
        wdata_q <= pwdata;
        strb_q  <= pstrb;
      end
    end
  end

  // Storage is deliberately left out of reset so contents survive rst_n.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_idx] <= (mem[mem_idx] & ~wmask) | (acc_wdata & wmask);
    end
  end

  assign prdata  = prdata_q;
  assign pready  = pready_q;
  assign pslverr = pslverr_q;

endmodule

// File: tb/tb_apb4_mem_slave.sv
// Bench for apb4_mem_slave: two instances (0 and 2 wait states) driven from one bus,
// expected responses queued at setup and checked when pready arrives.
module tb_apb4_mem_slave;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        psel0 = 1'b0, psel2 = 1'b0;
  logic        penable = 1'b0;
  logic        pwrite = 1'b0;
  logic [11:0] paddr = '0;
  logic [31:0] pwdata = '0;
  logic [3:0]  pstrb = '0;
  logic [31:0] prdata0, prdata2;
  logic        pready0, pready2, pslverr0, pslverr2;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] data;
    logic        err;
    logic        is_read;
  } exp_t;
  exp_t sb_q[$];

  logic [31:0] m0 [0:255];
  logic [31:0] m2 [0:255];

  always #5 clk = ~clk;

  apb4_mem_slave #(.DATA_W(32), .ADDR_W(12), .DEPTH(256), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .psel(psel0), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb),
    .prdata(prdata0), .pready(pready0), .pslverr(pslverr0)
  );

  apb4_mem_slave #(.DATA_W(32), .ADDR_W(12), .DEPTH(256), .WAIT_CYCLES(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .psel(psel2), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb),
    .prdata(prdata2), .pready(pready2), .pslverr(pslverr2)
  );

  function automatic logic cur_pready(input int w);
    return (w == 2) ? pready2 : pready0;
  endfunction
  function automatic logic cur_pslverr(input int w);
    return (w == 2) ? pslverr2 : pslverr0;
  endfunction
  function automatic logic [31:0] cur_prdata(input int w);
    return (w == 2) ? prdata2 : prdata0;
  endfunction

  // One complete APB transfer on instance w (0 or 2 wait states).
  task automatic xfer(input int w, input logic wr, input logic [11:0] addr,
                      input logic [31:0] data, input logic [3:0] strb);
    exp_t e;
    int lat;
    logic got;
    logic [31:0] old;
    logic [31:0] mask;
    e.err = (addr[1:0] != 2'b00) || ((addr >> 2) >= 12'd256);
    e.is_read = !wr;
    e.data = '0;
    if (!e.err) begin
      old = (w == 2) ? m2[addr[9:2]] : m0[addr[9:2]];
      if (wr) begin
        mask = {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
        if (w == 2) m2[addr[9:2]] = (old & ~mask) | (data & mask);
        else        m0[addr[9:2]] = (old & ~mask) | (data & mask);
      end else begin
        e.data = old;
      end
    end
    sb_q.push_back(e);

    @(posedge clk); #1;
    psel0 = (w == 0); psel2 = (w == 2);
    penable = 1'b0; pwrite = wr; paddr = addr; pwdata = data; pstrb = strb;
    lat = 0; got = 1'b0;
    while (!got && lat < 20) begin
      @(posedge clk); #1;
      lat++;
      penable = 1'b1;
      if (cur_pready(w)) begin
        got = 1'b1;
      end else begin
        checks++;
        if (cur_prdata(w) !== 32'h0 || cur_pslverr(w) !== 1'b0) begin
          failures++;
          $display("FAIL idle_outputs w=%0d addr=%h: prdata=%h pslverr=%b, required 0/0",
                   w, addr, cur_prdata(w), cur_pslverr(w));
        end
      end
      // Bus changes after setup must have no effect.
      pwdata = $urandom;
      paddr  = 12'($urandom);
      pstrb  = 4'($urandom);
    end

    checks++;
    if (!got || lat != 1 + w) begin
      failures++;
      $display("FAIL latency w=%0d addr=%h: pready after %0d cycles (seen=%b), required %0d",
               w, addr, lat, got, 1 + w);
    end
    e = sb_q.pop_front();
    checks++;
    if (cur_pslverr(w) !== e.err) begin
      failures++;
      $display("FAIL pslverr w=%0d addr=%h: got %b, required %b", w, addr, cur_pslverr(w), e.err);
    end
    if (e.is_read || e.err) begin
      checks++;
      if (cur_prdata(w) !== e.data) begin
        failures++;
        $display("FAIL prdata w=%0d addr=%h: got %h, required %h", w, addr, cur_prdata(w), e.data);
      end
    end
    $display("xfer w=%0d %s addr=%h wdata=%h strb=%h -> lat=%0d prdata=%h pslverr=%b",
             w, wr ? "WR" : "RD", addr, data, strb, lat, cur_prdata(w), cur_pslverr(w));
    psel0 = 1'b0; psel2 = 1'b0; penable = 1'b0;
  endtask

  // Watch instance w for n cycles and require that pready never rises.
  task automatic expect_no_pready(input int w, input int n, input string name);
    logic seen = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      if (cur_pready(w)) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      failures++;
      $display("FAIL %s: pready observed high, required low", name);
    end
    $display("%s: no-pready window of %0d cycles checked", name, n);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({pready0, pslverr0, prdata0, pready2, pslverr2, prdata2} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: %b %b %h %b %b %h, required all 0",
               pready0, pslverr0, prdata0, pready2, pslverr2, prdata2);
    end
    $display("reset: outputs checked");
    rst_n = 1'b1;
  endtask

  task automatic test_basic;
    xfer(0, 1'b1, 12'h010, 32'hDEADBEEF, 4'hF);
    xfer(0, 1'b0, 12'h010, 32'h0, 4'hF);
  endtask

  task automatic test_partial_strobe;
    xfer(0, 1'b1, 12'h020, 32'h11223344, 4'hF);
    xfer(0, 1'b1, 12'h020, 32'hAABBCCDD, 4'h5);
    xfer(0, 1'b0, 12'h020, 32'h0, 4'h0);
    checks++;
    if (m0[8] !== 32'h11BB33DD) begin
      failures++;
      $display("FAIL strobe_model: model holds %h, required 11bb33dd", m0[8]);
    end
  endtask

  task automatic test_wait_states;
    xfer(2, 1'b1, 12'h044, 32'hCAFEF00D, 4'hF);
    xfer(2, 1'b0, 12'h044, 32'h0, 4'hA);
  endtask

  task automatic test_abort;
    xfer(2, 1'b1, 12'h040, 32'h01020304, 4'hF);
    @(posedge clk); #1;
    psel2 = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 12'h040;
    pwdata = 32'hFFFFFFFF; pstrb = 4'hF;
    @(posedge clk); #1;
    penable = 1'b1;
    @(posedge clk); #1;
    psel2 = 1'b0; penable = 1'b0;
    expect_no_pready(2, 6, "abort_no_pready");
    xfer(2, 1'b0, 12'h040, 32'h0, 4'hF);
  endtask

  task automatic test_errors;
    xfer(0, 1'b1, 12'h000, 32'h0BADF00D, 4'hF);
    xfer(0, 1'b1, 12'h402, 32'h11111111, 4'hF);
    xfer(0, 1'b1, 12'h400, 32'h22222222, 4'hF);
    xfer(0, 1'b1, 12'h002, 32'hFFFFFFFF, 4'hF);
    xfer(0, 1'b0, 12'h401, 32'h0, 4'hF);
    xfer(0, 1'b0, 12'h000, 32'h0, 4'hF);
  endtask

  task automatic test_idle_penable;
    @(posedge clk); #1;
    psel0 = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = 12'h000;
    pwdata = 32'h33333333; pstrb = 4'hF;
    expect_no_pready(0, 4, "idle_penable_ignored");
    psel0 = 1'b0; penable = 1'b0;
    xfer(0, 1'b0, 12'h000, 32'h0, 4'hF);
  endtask

  task automatic test_back_to_back;
    for (int i = 0; i < 4; i++) xfer(0, 1'b1, 12'(12'h080 + 4 * i), $urandom, 4'hF);
    for (int i = 0; i < 4; i++) xfer(0, 1'b0, 12'(12'h080 + 4 * i), 32'h0, 4'hF);
    xfer(2, 1'b1, 12'h090, 32'h89ABCDEF, 4'hF);
    xfer(2, 1'b0, 12'h090, 32'h0, 4'hF);
  endtask

  task automatic test_reset_mid;
    // Reset during WAIT of a write: nothing reaches memory.
    xfer(2, 1'b1, 12'h030, 32'h12345678, 4'hF);
    @(posedge clk); #1;
    psel2 = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 12'h030;
    pwdata = 32'h5A5A5A5A; pstrb = 4'hF;
    @(posedge clk); #1;
    penable = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({pready2, pslverr2, prdata2} !== '0) begin
      failures++;
      $display("FAIL reset_wait_outputs: %b %b %h, required all 0", pready2, pslverr2, prdata2);
    end
    psel2 = 1'b0; penable = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    expect_no_pready(2, 6, "reset_wait_no_pready");
    xfer(2, 1'b0, 12'h030, 32'h0, 4'hF);

    // Reset during RESP of a read: outputs clear without waiting for a clock.
    @(posedge clk); #1;
    psel0 = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 12'h010; pstrb = 4'hF;
    @(posedge clk); #1;
    penable = 1'b1;
    checks++;
    if (pready0 !== 1'b1 || prdata0 !== m0[4]) begin
      failures++;
      $display("FAIL resp_before_reset: pready=%b prdata=%h, required 1/%h", pready0, prdata0, m0[4]);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({pready0, pslverr0, prdata0} !== '0) begin
      failures++;
      $display("FAIL reset_resp_outputs: %b %b %h, required all 0", pready0, pslverr0, prdata0);
    end
    $display("reset mid-transfer: outputs checked");
    psel0 = 1'b0; penable = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    xfer(0, 1'b0, 12'h010, 32'h0, 4'hF);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_partial_strobe();
    test_wait_states();
    test_abort();
    test_errors();
    test_idle_penable();
    test_back_to_back();
    test_reset_mid();
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", sb_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
